reward_scan_gen: RTL and testbench
==================================

# reward_scan_gen

Sequential, parametrised reward generator for the tic-tac-toe learning agent. It accepts an N×N board snapshot through a valid/ready handshake and scans one winning line per clock (all rows, then all columns, then both diagonals). It classifies the position as agent win, opponent win, draw, invalid or ongoing, and returns a signed reward with an outcome code. It sits between the board-state register and the Q-value update logic.

## Interface
- N, 3: board side length; winning line length is N (legal range 3..8).
- RW, 8: reward width, two's-complement signed.
- WIN_REWARD, 100: reward when only the agent owns a complete line.
- LOSS_REWARD, -100: reward when only the opponent owns a complete line.
- DRAW_REWARD, 10: reward for a full board with no complete line.
- STEP_REWARD, -1: reward for a non-full board with no complete line.
- INVALID_REWARD, -128: reward for an illegal cell code, or when both players own a line.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  board snapshot valid.
- in_ready  out  1  block can accept a board; high only in IDLE.
- board  in  2*N*N  cell i occupies bits [2i+1:2i]; cell 0 is top-left, row-major. Codes: 00 empty, 01 agent, 10 opponent, 11 illegal.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- reward  out  RW  signed reward.
- outcome  out  3  0 step, 1 agent win, 2 opponent win, 3 draw, 4 invalid.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset enters IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch board.
  - Compute and latch flags: illegal (any cell = 11) and full (no cell = 00).
  - Clear the agent-line and opponent-line flags, set line_idx=0, go to SCAN.
- SCAN:
  - Each cycle evaluates line line_idx: 0..N-1 are rows, N..2N-1 are columns, 2N is the main diagonal (cells 0, N+1, ...), 2N+1 is the anti-diagonal (cells N-1, 2N-2, ...).
  - Set the agent flag if all N cells are 01; set the opponent flag if all N cells are 10. Flags are sticky.
  - line_idx counts up. After line 2N+1, go to DONE. The scan always covers all lines; there is no early exit.
- DONE:
  - Register reward and outcome using this priority: illegal, or both line flags set → invalid; agent flag → win; opponent flag → loss; full → draw; else → step.
  - Hold out_valid, reward and outcome stable until out_ready is high. On that handshake go to IDLE.
- in_valid is ignored outside IDLE; board is sampled only at the accepting edge.
- Parameter reward values are truncated to RW bits. Choosing values that fit in RW is the integrator's responsibility.
- line_idx width is clog2(2N+2).

## Timing
- Reset values: out_valid=0, reward=0, outcome=0, FSM=IDLE, line_idx=0, all flags 0. in_ready=1 after reset.
- Reset mid-SCAN or mid-DONE aborts at once: the result is lost and no out_valid is produced.
- Input handshake at edge k → SCAN during cycles k..k+2N+1 → out_valid rises after edge k+2N+2. For N=3 that is 8 cycles.
- Output handshake at edge m → out_valid=0 and in_ready=1 after edge m. A new board is accepted no earlier than edge m+1.
- Minimum period per board with out_ready held high: 2N+4 cycles.
- in_ready, out_valid, reward and outcome are derived from registers only; there are no combinational input-to-output paths.

## Test plan
All cases use N=3 and default rewards unless stated.
- **Empty board:** board=18'b0 with out_ready=1 → out_valid exactly 8 cycles after acceptance, outcome=0, reward=-1 (8'hFF).
- **Agent win:** board=18'b010101100110100110 (cells 6,7,8 agent) → outcome=1, reward=100. **Opponent win:** board=18'b101010011001011001 → outcome=2, reward=-100.
- **Draw:** cells 0..8 = agent, opp, agent, agent, opp, opp, opp, agent, agent → outcome=3, reward=10. **Both lines:** top row agent and bottom row opponent → outcome=4, reward=-128.
- **Illegal cell:** cell 4=11, others empty → outcome=4, reward=-128.
- **Backpressure and gating:**
  - Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0.
  - in_valid pulses during SCAN are ignored.
  - After the handshake, the next board is accepted with the same 8-cycle latency.
- **Reset and N=4:**
  - Assert rst_n=0 during SCAN cycle 3 → out_valid stays 0; outputs return to reset values.
  - With N=4, main diagonal all agent → outcome=1 after exactly 10 cycles.

Source files
------------

// File: rtl/reward_scan_gen.sv
// Sequential tic-tac-toe reward generator: latches an NxN board, scans one winning
// line per clock (rows, columns, diagonals), then holds a classified reward for the consumer.
module reward_scan_gen #(
    parameter int unsigned N              = 3,
    parameter int unsigned RW             = 8,
    parameter int          WIN_REWARD     = 100,
    parameter int          LOSS_REWARD    = -100,
    parameter int          DRAW_REWARD    = 10,
    parameter int          STEP_REWARD    = -1,
    parameter int          INVALID_REWARD = -128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*N*N-1:0]     board,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [RW-1:0] reward,
    output logic [2:0]           outcome
);
    localparam int unsigned CELLS = N * N;
    localparam int unsigned BW    = 2 * CELLS;
    localparam int unsigned LINES = 2 * N + 2;
    localparam int unsigned LW    = $clog2(LINES);
    localparam int unsigned LSZ   = 1 << LW;
    localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);

    localparam logic [2:0] OC_STEP    = 3'd0;
    localparam logic [2:0] OC_WIN     = 3'd1;
    localparam logic [2:0] OC_LOSS    = 3'd2;
    localparam logic [2:0] OC_DRAW    = 3'd3;
    localparam logic [2:0] OC_INVALID = 3'd4;

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_e;

    state_e               state_q, state_d;
    logic [BW-1:0]        board_q, board_d;
    logic                 illegal_q, illegal_d;
    logic                 full_q, full_d;
    logic                 agent_q, agent_d;
    logic                 opp_q, opp_d;
    logic [LW-1:0]        line_idx_q, line_idx_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [RW-1:0] reward_q, reward_d;
    logic [2:0]           outcome_q, outcome_d;

    logic                 in_illegal_c, in_full_c;
    logic [LSZ-1:0]       agent_line_c, opp_line_c;

    // Snapshot flags, computed on the incoming board so they are ready at acceptance
    always_comb begin
        in_illegal_c = 1'b0;
        in_full_c    = 1'b1;
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (board[2*i +: 2] == 2'b11) in_illegal_c = 1'b1;
            if (board[2*i +: 2] == 2'b00) in_full_c    = 1'b0;
        end
    end

    // Ownership of every line of the latched board; the scan selects one per cycle
    always_comb begin
        agent_line_c = '1;
        opp_line_c   = '1;
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
                if (board_q[2*(r*N+c) +: 2] != 2'b01) begin
                    agent_line_c[r]   = 1'b0;
                    agent_line_c[N+c] = 1'b0;
                    if (r == c)         agent_line_c[2*N]   = 1'b0;
                    if (r + c == N - 1) agent_line_c[2*N+1] = 1'b0;
                end
                if (board_q[2*(r*N+c) +: 2] != 2'b10) begin
                    opp_line_c[r]   = 1'b0;
                    opp_line_c[N+c] = 1'b0;
                    if (r == c)         opp_line_c[2*N]   = 1'b0;
                    if (r + c == N - 1) opp_line_c[2*N+1] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)                    state_d = SCAN;
            SCAN:    if (line_idx_q == LAST_LINE)     state_d = DONE;
            DONE:    if (out_ready)                   state_d = IDLE;
            default:                                  state_d = IDLE;
        endcase
    end

    // Datapath next-state; the result is classified on the edge that scans the last line
    always_comb begin
        board_d     = board_q;
        illegal_d   = illegal_q;
        full_d      = full_q;
        agent_d     = agent_q;
        opp_d       = opp_q;
        line_idx_d  = line_idx_q;
        out_valid_d = out_valid_q;
        reward_d    = reward_q;
        outcome_d   = outcome_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    board_d    = board;
                    illegal_d  = in_illegal_c;
                    full_d     = in_full_c;
                    agent_d    = 1'b0;
                    opp_d      = 1'b0;
                    line_idx_d = '0;
                end
            end
            SCAN: begin
                agent_d    = agent_q | agent_line_c[line_idx_q];
                opp_d      = opp_q | opp_line_c[line_idx_q];
                line_idx_d = line_idx_q + LW'(1);
                if (line_idx_q == LAST_LINE) begin
                    line_idx_d  = '0;
                    out_valid_d = 1'b1;
                    if (illegal_q || (agent_d && opp_d)) begin
                        reward_d  = RW'(INVALID_REWARD);
                        outcome_d = OC_INVALID;
                    end else if (agent_d) begin
                        reward_d  = RW'(WIN_REWARD);
                        outcome_d = OC_WIN;
                    end else if (opp_d) begin
                        reward_d  = RW'(LOSS_REWARD);
                        outcome_d = OC_LOSS;
                    end else if (full_q) begin
                        reward_d  = RW'(DRAW_REWARD);
                        outcome_d = OC_DRAW;
                    end else begin
                        reward_d  = RW'(STEP_REWARD);
                        outcome_d = OC_STEP;
                    end
                end
            end
            DONE: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_q     <= '0;
            illegal_q   <= 1'b0;
            full_q      <= 1'b0;
            agent_q     <= 1'b0;
            opp_q       <= 1'b0;
            line_idx_q  <= '0;
            out_valid_q <= 1'b0;
            reward_q    <= '0;
            outcome_q   <= OC_STEP;
        end else begin
            board_q     <= board_d;
            illegal_q   <= illegal_d;
            full_q      <= full_d;
            agent_q     <= agent_d;
            opp_q       <= opp_d;
            line_idx_q  <= line_idx_d;
            out_valid_q <= out_valid_d;
            reward_q    <= reward_d;
            outcome_q   <= outcome_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign reward    = reward_q;
    assign outcome   = outcome_q;

endmodule

// File: tb/tb_reward_scan_gen.sv
// Randomised and directed bench for reward_scan_gen (N=3 and N=4) against a
// line-counting board model and a cycle-level handshake model.
module tb_reward_scan_gen;
    logic clk;
    logic rst_n;

    logic              in_valid3, in_ready3, out_valid3, out_ready3;
    logic [17:0]       board3;
    logic signed [7:0] reward3;
    logic [2:0]        outcome3;

    logic              in_valid4, in_ready4, out_valid4, out_ready4;
    logic [31:0]       board4;
    logic signed [7:0] reward4;
    logic [2:0]        outcome4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    reward_scan_gen #(.N(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3), .board(board3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .reward(reward3), .outcome(outcome3)
    );

    reward_scan_gen #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .board(board4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .reward(reward4), .outcome(outcome4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outcome from the board rules: count owned cells along every line
    function automatic int model_outcome(input int n, input logic [127:0] b);
        bit ag = 0, op = 0, ill = 0, full = 1;
        int ra, ro, ca, co, da, dob, xa, xo;
        for (int i = 0; i < n * n; i++) begin
            if (b[2*i +: 2] == 2'b11) ill = 1;
            if (b[2*i +: 2] == 2'b00) full = 0;
        end
        da = 0; dob = 0; xa = 0; xo = 0;
        for (int k = 0; k < n; k++) begin
            ra = 0; ro = 0; ca = 0; co = 0;
            for (int j = 0; j < n; j++) begin
                ra += int'(b[2*(k*n+j) +: 2] == 2'b01);
                ro += int'(b[2*(k*n+j) +: 2] == 2'b10);
                ca += int'(b[2*(j*n+k) +: 2] == 2'b01);
                co += int'(b[2*(j*n+k) +: 2] == 2'b10);
            end
            if (ra == n || ca == n) ag = 1;
            if (ro == n || co == n) op = 1;
            da  += int'(b[2*(k*n+k) +: 2] == 2'b01);
            dob += int'(b[2*(k*n+k) +: 2] == 2'b10);
            xa  += int'(b[2*(k*n+n-1-k) +: 2] == 2'b01);
            xo  += int'(b[2*(k*n+n-1-k) +: 2] == 2'b10);
        end
        if (da == n || xa == n) ag = 1;
        if (dob == n || xo == n) op = 1;
        if (ill || (ag && op)) return 4;
        if (ag)   return 1;
        if (op)   return 2;
        if (full) return 3;
        return 0;
    endfunction

    function automatic int model_reward(input int oc);
        case (oc)
            1:       return 100;
            2:       return -100;
            3:       return 10;
            4:       return -128;
            default: return -1;
        endcase
    endfunction

    function automatic logic [127:0] rand_board(input int n);
        logic [127:0] b = '0;
        int v, line, who, idx;
        for (int i = 0; i < n * n; i++) begin
            v = $urandom_range(0, 15);
            b[2*i +: 2] = (v < 5) ? 2'b00 : (v < 10) ? 2'b01 : (v < 15) ? 2'b10 : 2'b11;
        end
        if ($urandom_range(0, 2) == 0) begin
            line = $urandom_range(0, 2 * n + 1);
            who  = $urandom_range(1, 2);
            for (int k = 0; k < n; k++) begin
                if (line < n)           idx = line * n + k;
                else if (line < 2 * n)  idx = k * n + (line - n);
                else if (line == 2 * n) idx = k * (n + 1);
                else                    idx = (n - 1) + k * (n - 1);
                b[2*idx +: 2] = 2'(who);
            end
        end
        return b;
    endfunction

    // Cycle-level handshake model for the N=3 instance, compared every negedge
    bit pend = 0;
    int due  = 0;
    int exp_oc = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
            check("rst_out_valid", out_valid3, 0);
            check("rst_reward", reward3, 0);
            check("rst_outcome", outcome3, 0);
            check("rst_in_ready", in_ready3, 1);
        end else begin
            check("mon_in_ready", in_ready3, !pend);
            check("mon_out_valid", out_valid3, pend && (cyc >= due));
            if (pend && cyc >= due) begin
                check("mon_outcome", outcome3, exp_oc);
                check("mon_reward", reward3, model_reward(exp_oc));
                if (out_ready3) pend = 0;
            end else if (!pend && in_valid3) begin
                pend   = 1;
                due    = cyc + 1 + 8;
                exp_oc = model_outcome(3, 128'(board3));
            end
        end
    end

    task automatic wait_idle3();
        int n = 0;
        while (!in_ready3 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("idle3_timeout", in_ready3, 1);
    endtask

    task automatic run3(input string name, input logic [17:0] b, input int oc,
                        input int rw, input bit noise);
        int lat = 0;
        wait_idle3();
        board3 = b; in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        while (!out_valid3 && lat < 40) begin
            if (noise) begin
                in_valid3 = 1'($urandom_range(0, 1));
                board3    = 18'($urandom);
            end
            @(posedge clk); #1; lat++;
        end
        in_valid3 = 1'b0;
        check({name, "_latency"}, lat, 8);
        check({name, "_outcome"}, outcome3, oc);
        check({name, "_reward"}, reward3, rw);
        if (out_ready3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run4(input string name, input logic [31:0] b, input int oc);
        int lat = 0;
        int n = 0;
        while (!in_ready4 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        board4 = b; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        while (!out_valid4 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check({name, "_latency"}, lat, 10);
        check({name, "_outcome"}, outcome4, oc);
        check({name, "_reward"}, reward4, model_reward(oc));
        @(posedge clk); #1;
        check({name, "_released"}, out_valid4, 0);
    endtask

    localparam logic [17:0] B_EMPTY = 18'b0;
    localparam logic [17:0] B_AWIN  = 18'b010101100110100110;
    localparam logic [17:0] B_OWIN  = 18'b101010011001011001;
    localparam logic [17:0] B_DRAW  = {2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
    localparam logic [17:0] B_BOTH  = 18'b101010_000000_010101;
    localparam logic [17:0] B_ILL   = 18'h00300;
    localparam logic [31:0] B4_DIAG = 32'h40100401;

    initial begin
        logic [127:0] rb;
        int oc, n;
        rst_n = 1'b0;
        in_valid3 = 1'b0; board3 = '0; out_ready3 = 1'b1;
        in_valid4 = 1'b0; board4 = '0; out_ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pin the board model to hand-derived classifications
        check("model_empty", model_outcome(3, 128'(B_EMPTY)), 0);
        check("model_awin", model_outcome(3, 128'(B_AWIN)), 1);
        check("model_owin", model_outcome(3, 128'(B_OWIN)), 2);
        check("model_draw", model_outcome(3, 128'(B_DRAW)), 3);
        check("model_both", model_outcome(3, 128'(B_BOTH)), 4);
        check("model_ill", model_outcome(3, 128'(B_ILL)), 4);
        check("model_diag4", model_outcome(4, 128'(B4_DIAG)), 1);

        run3("empty", B_EMPTY, 0, -1, 1'b0);
        run3("awin", B_AWIN, 1, 100, 1'b0);
        run3("owin", B_OWIN, 2, -100, 1'b1);
        run3("draw", B_DRAW, 3, 10, 1'b0);
        run3("both", B_BOTH, 4, -128, 1'b1);
        run3("illegal", B_ILL, 4, -128, 1'b0);

        // Backpressure: result held while the consumer stalls
        out_ready3 = 1'b0;
        run3("bp", B_AWIN, 1, 100, 1'b1);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_hold_valid", out_valid3, 1);
            check("bp_hold_in_ready", in_ready3, 0);
            check("bp_hold_outcome", outcome3, 1);
            check("bp_hold_reward", reward3, 100);
        end
        out_ready3 = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", out_valid3, 0);
        check("bp_release_in_ready", in_ready3, 1);
        run3("after_bp", B_OWIN, 2, -100, 1'b0);

        // Reset during the scan drops the result
        wait_idle3();
        board3 = B_AWIN; in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid3, 0);
        check("abort_reward", reward3, 0);
        check("abort_outcome", outcome3, 0);
        check("abort_in_ready", in_ready3, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            check("abort_no_result", out_valid3, 0);
        end

        run4("n4_diag", B4_DIAG, 1);
        for (int i = 0; i < 8; i++) begin
            rb = rand_board(4);
            run4("n4_rand", rb[31:0], model_outcome(4, rb));
        end

        // Random boards with random consumer stalls, checked by the monitor
        for (int i = 0; i < 60; i++) begin
            wait_idle3();
            rb = rand_board(3);
            board3 = rb[17:0]; in_valid3 = 1'b1;
            @(posedge clk); #1;
            in_valid3 = 1'b0;
            n = 0;
            while (n < 60) begin
                out_ready3 = 1'($urandom_range(0, 1));
                @(posedge clk); #1; n++;
                if (in_ready3) break;
            end
            check("rand_complete", in_ready3, 1);
            out_ready3 = 1'b1;
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
